// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle for the uart transmit arbiter: per-source byte
// handshake plus the arbiter's ready/grant feedback.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;

   modport master (
      output req_valid, req_data, req_last,
      input  req_ready, grant
   );

   modport slave (
      input  req_valid, req_data, req_last,
      output req_ready, grant
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter between NUM_REQ byte
// sources, with per-packet ownership lock and an idle-owner lock timeout.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | arbitrate when uart is idle; accept one byte from the winner
//   LAUNCH     | uart_tx_trigger_o high for this single cycle
//   WAIT_START | wait for the uart to report busy (complete low)
//   WAIT_DONE  | wait for frame end; count it, release lock on a last byte
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int CNT_W        = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   uart_tx_arbiter_if.slave    req_if,
   output logic [7:0]          uart_tx_data_o,
   output logic                uart_tx_trigger_o,
   input  logic                uart_tx_complete_i,
   output logic                busy_o,
   output logic [CNT_W-1:0]    bytes_sent_o
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

   state_t             state_q;
   logic               lock_q;
   logic               last_q;
   logic [IW-1:0]      owner_q;
   logic [IW-1:0]      rr_ptr_q;
   logic [TW-1:0]      tmo_cnt_q;
   logic [NUM_REQ-1:0] grant_q;

   logic               win_valid;
   logic [IW-1:0]      win_idx;
   logic [NUM_REQ-1:0] ready;
   logic               tmo_fire;
   int                 cand;
   logic [IW-1:0]      cand_idx;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   // The timeout takes precedence over an owner that reasserts valid in the same cycle.
   assign tmo_fire = (state_q == IDLE) && lock_q && (tmo_cnt_q == TW'(LOCK_TIMEOUT));

   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      if (rst_ni && (state_q == IDLE) && uart_tx_complete_i && !tmo_fire) begin
         if (lock_q) begin
            win_valid = req_if.req_valid[owner_q];
            win_idx   = owner_q;
         end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
               cand = int'(rr_ptr_q) + i;
               if (cand >= NUM_REQ) cand = cand - NUM_REQ;
               cand_idx = IW'(cand);
               if (!win_valid && req_if.req_valid[cand_idx]) begin
                  win_valid = 1'b1;
                  win_idx   = cand_idx;
               end
            end
         end
      end
   end

   assign ready            = win_valid ? (NUM_REQ'(1) << win_idx) : '0;
   assign req_if.req_ready = ready;
   assign req_if.grant     = grant_q;
   assign busy_o           = (state_q != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q           <= IDLE;
         lock_q            <= 1'b0;
         last_q            <= 1'b0;
         owner_q           <= '0;
         rr_ptr_q          <= '0;
         tmo_cnt_q         <= '0;
         grant_q           <= '0;
         uart_tx_data_o    <= 8'h00;
         uart_tx_trigger_o <= 1'b0;
         bytes_sent_o      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tmo_fire) begin
                  lock_q    <= 1'b0;
                  grant_q   <= '0;
                  rr_ptr_q  <= next_idx(owner_q);
                  tmo_cnt_q <= '0;
               end else if (win_valid) begin
                  uart_tx_data_o    <= req_if.req_data[{win_idx, 3'b000} +: 8];
                  last_q            <= req_if.req_last[win_idx];
                  grant_q           <= ready;
                  lock_q            <= 1'b1;
                  owner_q           <= win_idx;
                  tmo_cnt_q         <= '0;
                  uart_tx_trigger_o <= 1'b1;
                  state_q           <= LAUNCH;
               end else if (lock_q && !req_if.req_valid[owner_q]) begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            LAUNCH: begin
               uart_tx_trigger_o <= 1'b0;
               state_q           <= WAIT_START;
            end
            WAIT_START: begin
               if (!uart_tx_complete_i) state_q <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (uart_tx_complete_i) begin
                  bytes_sent_o <= bytes_sent_o + 1'b1;
                  if (last_q) begin
                     lock_q   <= 1'b0;
                     grant_q  <= '0;
                     rr_ptr_q <= next_idx(owner_q);
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive the bus, a
// simple uart model consumes triggers and checks each frame against the queue.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ      = 4;
   localparam int LOCK_TIMEOUT = 16;
   localparam int CNT_W        = 4;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic [7:0]       uart_tx_data_o;
   logic             uart_tx_trigger_o;
   logic             uart_tx_complete_i;
   logic             busy_o;
   logic [CNT_W-1:0] bytes_sent_o;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) arb_if();

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .req_if             (arb_if),
      .uart_tx_data_o     (uart_tx_data_o),
      .uart_tx_trigger_o  (uart_tx_trigger_o),
      .uart_tx_complete_i (uart_tx_complete_i),
      .busy_o             (busy_o),
      .bytes_sent_o       (bytes_sent_o)
   );

   always #5 clk_i = ~clk_i;

   typedef logic [8:0] byte_q_t [$];
   typedef struct packed {
      logic [3:0] grant;
      logic [7:0] data;
   } sb_t;

   byte_q_t    rq [NUM_REQ];
   sb_t        exp_q [$];
   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         acc_cnt [NUM_REQ];
   int         acc_cyc [NUM_REQ];
   int         trig_cnt = 0;
   int         trig_cyc = 0;
   int         frame_len = 6;
   int         frame_left = 0;
   logic       uart_busy = 1'b0;
   logic       aborted = 1'b0;
   logic       prev_trig = 1'b0;
   logic [7:0] cur_data = 8'h00;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input int k, input logic [7:0] d, input logic last);
      logic [3:0] g;
      g = 4'b0001 << k;
      rq[k].push_back({last, d});
      exp_q.push_back({g, d});
   endtask

   function automatic logic all_empty();
      logic e;
      e = (exp_q.size() == 0);
      for (int k = 0; k < NUM_REQ; k++) if (rq[k].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic do_reset(input string tag);
      @(negedge clk_i);
      rst_ni = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rq[k].delete();
         acc_cnt[k] = 0;
      end
      exp_q.delete();
      #1;
      check({tag, "_rst_ready"},   32'(arb_if.req_ready), 32'h0);
      check({tag, "_rst_grant"},   32'(arb_if.grant),     32'h0);
      check({tag, "_rst_data"},    32'(uart_tx_data_o),   32'h0);
      check({tag, "_rst_trigger"}, 32'(uart_tx_trigger_o), 32'h0);
      check({tag, "_rst_busy"},    32'(busy_o),           32'h0);
      check({tag, "_rst_bytes"},   32'(bytes_sent_o),     32'h0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         #2;
         if (all_empty() && !uart_busy && !busy_o) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_drain"}, 32'(ok), 32'h1);
   endtask

   task automatic wait_acc(input string tag, input int k, input int n, input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         #2;
         if (acc_cnt[k] >= n) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_accept"}, 32'(ok), 32'h1);
   endtask

   // Requester driver: present queue heads at negedge, retire on valid & ready just before posedge.
   initial begin
      logic [NUM_REQ-1:0]   v;
      logic [NUM_REQ-1:0]   l;
      logic [8*NUM_REQ-1:0] d;
      arb_if.req_valid = '0;
      arb_if.req_data  = '0;
      arb_if.req_last  = '0;
      forever begin
         @(negedge clk_i);
         v = '0;
         l = '0;
         d = '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (rq[k].size() > 0) begin
               v[k]       = 1'b1;
               d[8*k +: 8] = rq[k][0][7:0];
               l[k]       = rq[k][0][8];
            end
         end
         arb_if.req_valid = v;
         arb_if.req_data  = d;
         arb_if.req_last  = l;
         #4;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (v[k] && arb_if.req_ready[k] && rq[k].size() > 0) begin
               void'(rq[k].pop_front());
               acc_cnt[k]++;
               acc_cyc[k] = cyc;
            end
         end
      end
   end

   // Uart model and scoreboard consumer.
   initial begin
      sb_t e;
      uart_tx_complete_i = 1'b1;
      forever begin
         @(negedge clk_i);
         if (uart_tx_trigger_o) begin
            trig_cnt++;
            trig_cyc = cyc;
            check("trig_single_cycle", 32'(prev_trig), 32'h0);
            check("trig_while_uart_idle", 32'(uart_busy), 32'h0);
            if (exp_q.size() == 0) begin
               check("sb_unexpected_frame", 32'(exp_q.size()), 32'h1);
            end else begin
               e = exp_q.pop_front();
               check("sb_grant", 32'(arb_if.grant), 32'(e.grant));
               check("sb_data",  32'(uart_tx_data_o), 32'(e.data));
            end
            cur_data           = uart_tx_data_o;
            uart_busy          = 1'b1;
            frame_left         = frame_len;
            uart_tx_complete_i = 1'b0;
         end else if (uart_busy) begin
            if (frame_left > 0) begin
               frame_left--;
            end else begin
               if (!aborted) check("frame_data_stable", 32'(uart_tx_data_o), 32'(cur_data));
               aborted            = 1'b0;
               uart_busy          = 1'b0;
               uart_tx_complete_i = 1'b1;
            end
         end
         prev_trig = uart_tx_trigger_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int tc;
      int dly;
      logic ok;

      // single requester, single byte
      do_reset("t1");
      send(0, 8'hA5, 1'b1);
      wait_idle("t1", 100);
      check("t1_ready_pulses", 32'(acc_cnt[0]), 32'd1);
      check("t1_trig_latency", 32'(trig_cyc - acc_cyc[0]), 32'd1);
      check("t1_bytes", 32'(bytes_sent_o), 32'd1);
      check("t1_grant_idle", 32'(arb_if.grant), 32'h0);

      // all four requesters contending
      do_reset("t2");
      send(0, 8'h10, 1'b1);
      send(1, 8'h21, 1'b1);
      send(2, 8'h32, 1'b1);
      send(3, 8'h43, 1'b1);
      send(0, 8'h14, 1'b1);
      wait_idle("t2", 300);
      check("t2_bytes", 32'(bytes_sent_o), 32'd5);
      check("t2_r0_accepts", 32'(acc_cnt[0]), 32'd2);

      // packet lock holds off a waiting requester
      do_reset("t3");
      send(2, 8'hA0, 1'b0);
      send(2, 8'hA1, 1'b0);
      send(2, 8'hA2, 1'b1);
      wait_acc("t3_r2_first", 2, 1, 50);
      send(1, 8'hB1, 1'b1);
      wait_idle("t3", 300);
      check("t3_bytes", 32'(bytes_sent_o), 32'd4);
      check("t3_grant_idle", 32'(arb_if.grant), 32'h0);

      // lock timeout when the owner goes quiet mid-packet
      do_reset("t4");
      tc = trig_cnt;
      send(1, 8'h11, 1'b0);
      wait_acc("t4_r1", 1, 1, 50);
      send(3, 8'h33, 1'b1);
      ok = 1'b0;
      t0 = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         #2;
         if ((trig_cnt > tc) && !uart_busy && !busy_o) begin
            ok = 1'b1;
            t0 = cyc;
            break;
         end
      end
      check("t4_r1_frame_done", 32'(ok), 32'h1);
      repeat (8) @(negedge clk_i);
      #2;
      check("t4_lock_grant", 32'(arb_if.grant), 32'b0010);
      check("t4_r3_waits", 32'(arb_if.req_ready[3]), 32'h0);
      wait_acc("t4_r3", 3, 1, 100);
      dly = acc_cyc[3] - t0;
      check("t4_timeout_window", 32'((dly >= 16) && (dly <= 22)), 32'h1);
      wait_idle("t4", 100);
      check("t4_grant_idle", 32'(arb_if.grant), 32'h0);
      check("t4_bytes", 32'(bytes_sent_o), 32'd2);

      // async reset during a long frame
      do_reset("t5");
      frame_len = 200;
      tc = trig_cnt;
      send(0, 8'h3C, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (trig_cnt > tc) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_first_trigger", 32'(ok), 32'h1);
      repeat (5) @(negedge clk_i);
      aborted = 1'b1;
      rst_ni  = 1'b0;
      #1;
      check("t5_mid_grant",   32'(arb_if.grant), 32'h0);
      check("t5_mid_data",    32'(uart_tx_data_o), 32'h0);
      check("t5_mid_trigger", 32'(uart_tx_trigger_o), 32'h0);
      check("t5_mid_busy",    32'(busy_o), 32'h0);
      check("t5_mid_bytes",   32'(bytes_sent_o), 32'h0);
      send(1, 8'h5A, 1'b1);
      repeat (3) @(negedge clk_i);
      rst_ni    = 1'b1;
      frame_len = 6;
      tc        = trig_cnt;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         #2;
         if (!uart_busy) break;
      end
      check("t5_uart_finished", 32'(uart_busy), 32'h0);
      check("t5_no_trig_in_flight", 32'(trig_cnt), 32'(tc));
      wait_idle("t5", 100);
      check("t5_r1_accepts", 32'(acc_cnt[1]), 32'd1);
      check("t5_bytes", 32'(bytes_sent_o), 32'd1);

      // frame counter wrap with a 4-bit counter
      do_reset("t6");
      for (int i = 0; i < 17; i++) send(i % 4, 8'(i * 7 + 1), 1'b1);
      wait_idle("t6", 1000);
      check("t6_bytes_wrap", 32'(bytes_sent_o), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
